data_mem_arbiter: RTL and testbench
===================================

# data_mem_arbiter

- Sequences and shares the byte-wide data memory between two requesters: port A (core load/store unit) and port B (debug/loader).
- Arbitrates round-robin and issues each load as one memory access.
- Splits each store into one byte write per cycle, little-endian.
- Returns right-justified, zero-extended load data and reports completion or error per port.
- Sits between the requesters and the data memory; the memory's combinational read and 1-byte-per-clock write port are driven only by this block.

## Interface

Parameters:
- MEM_BYTES, 1024: memory size in bytes; used for bounds checking.

Ports (x = a or b; one set per requester):
- clk_i  input  1: single clock; all state updates on its rising edge.
- rst_ni  input  1: reset, asynchronous, active-low.
- x_req_i  input  1: request; held with its fields until x_gnt_o.
- x_we_i  input  1: 1 = store, 0 = load.
- x_addr_i  input  32: byte address.
- x_mode_i  input  2: 00 byte, 01 half, 10 word, 11 illegal.
- x_wdata_i  input  32: store data, right-justified.
- x_gnt_o  output  1: combinational; request accepted this cycle.
- x_done_o  output  1: one-cycle pulse; transaction finished.
- x_err_o  output  1: valid with x_done_o; transaction rejected.
- x_rdata_o  output  32: load result, valid with x_done_o; held until that port's next done.
- mem_we_o  output  1: memory write enable.
- mem_addr_o  output  32: memory address.
- mem_mode_o  output  2: memory read mode.
- mem_wdata_o  output  32: byte to write in [7:0]; [31:8] = 0.
- mem_rdata_i  input  32: combinational memory read data.

## Operation

- FSM states: IDLE and ACCESS.
- IDLE, arbitration:
  - Only one requester active: it is granted.
  - Both active: grant the port not granted last; priority pointer resets to A.
- IDLE, on grant:
  - Latch owner, we, addr, mode, wdata.
  - Set len = 1/2/4 for modes 00/01/10 and byte counter cnt = 0.
  - Go to ACCESS.
- Error check at grant: mode 11 or addr + len - 1 >= MEM_BYTES, computed in 33 bits so no wrap. On error:
  - Latch err and go to ACCESS for one cycle.
  - mem_we_o stays 0 and rdata is forced to 0.
- ACCESS, load:
  - Drive mem_addr_o = addr_q and mem_mode_o = mode_q.
  - Capture and right-justify mem_rdata_i: byte → {24'h0, rdata[31:24]}; half → {16'h0, rdata[31:16]}; word → unchanged.
  - Return to IDLE.
- ACCESS, store:
  - Drive mem_we_o = 1, mem_addr_o = addr_q + cnt, mem_wdata_o = {24'h0, wdata_q byte cnt} (byte 0 = [7:0]).
  - cnt increments each cycle.
  - When cnt == len - 1, return to IDLE.
- Store done leaves the owner's x_rdata_o unchanged.
- In IDLE: mem_we_o = 0, mem_addr_o = 0, mem_mode_o = 2'b10.
- Grants are never issued outside IDLE. Requests raised during ACCESS wait.

## Timing

- Reset values: all x_gnt_o/x_done_o/x_err_o = 0; x_rdata_o = 0; mem_we_o = 0; mem_addr_o = 0; mem_mode_o = 2'b10; mem_wdata_o = 0; FSM IDLE; priority on A.
- Grant in cycle T (IDLE).
- Load: ACCESS in T+1; x_done_o and x_rdata_o are registered and visible in T+2.
- Store of len N: memory writes at edges ending T+1..T+N; x_done_o in T+N+1.
- Error: one ACCESS cycle, no write; x_done_o = x_err_o = 1 in T+2.
- The done cycle is an IDLE cycle, so a new grant may coincide with done. Back-to-back loads reach one grant every 2 cycles.
- Reset asserted mid-store:
  - mem_we_o drops immediately (asynchronous).
  - Already-written bytes remain; no done is issued.
  - FSM returns to IDLE.
- Only done/err are pulses; the requester must deassert x_req_i after x_gnt_o or it is re-arbitrated.

## Test plan

- **Word store then load (port A):** store 0x88913416 to addr 8, then load word from 8.
  - Bytes 8..11 written 16,34,91,88 on 4 consecutive cycles; a_done_o at T+5.
  - Load returns 0x88913416 with a_done_o at T+2.
- **Half and byte loads:** memory[4..7] = 16,34,91,88.
  - Half load at 6 → 0x00008891.
  - Byte load at 5 → 0x00000034.
- **Contention:** a_req_i and b_req_i held high together after reset.
  - Grants alternate A, B, A, B.
  - A request that arrives during another port's store waits until IDLE.
- **Errors:** each case gives done+err, mem_we_o never 1, rdata = 0.
  - Mode 11 at addr 0.
  - Word store at addr 1022.
  - Word load at 0xFFFFFFFE (no wrap).
- **Reset mid-store:** word store 0xAABBCCDD at 16; drop rst_ni after 2 bytes written.
  - memory[16..17] = DD,CC; memory[18..19] unchanged.
  - No done; next request is granted normally.

Source files
------------

// File: rtl/data_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// data_mem_arbiter_if
//   Request/response bundle between one requester (core LSU or debug loader)
//   and the data memory arbiter.
//
//   req    requester -> arbiter  request, held with its fields until gnt
//   we     requester -> arbiter  1 = store, 0 = load
//   addr   requester -> arbiter  byte address
//   mode   requester -> arbiter  00 byte, 01 half, 10 word, 11 illegal
//   wdata  requester -> arbiter  store data, right-justified
//   gnt    arbiter -> requester  request accepted this cycle (combinational)
//   done   arbiter -> requester  one-cycle completion pulse
//   err    arbiter -> requester  transaction rejected, valid with done
//   rdata  arbiter -> requester  load result, held until the next done
// ---------------------------------------------------------------------------
interface data_mem_arbiter_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [1:0]  mode;
    logic [31:0] wdata;
    logic        gnt;
    logic        done;
    logic        err;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, mode, wdata,
        input  gnt, done, err, rdata
    );

    modport slave (
        input  req, we, addr, mode, wdata,
        output gnt, done, err, rdata
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// ---------------------------------------------------------------------------
// data_mem_arbiter
//   Shares a byte-wide data memory between port A (core load/store unit) and
//   port B (debug/loader). Round-robin arbitration, one memory access per
//   load, one little-endian byte write per cycle for stores. Loads return
//   right-justified, zero-extended data. Out-of-range or illegal-mode
//   requests complete with err and never touch the memory.
//
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   a, b         requester ports (data_mem_arbiter_if.slave)
//   mem_we_o     memory write enable
//   mem_addr_o   memory byte address
//   mem_mode_o   memory read mode
//   mem_wdata_o  byte to write in [7:0], upper bits zero
//   mem_rdata_i  combinational memory read data (left-justified)
// ---------------------------------------------------------------------------
module data_mem_arbiter #(
    parameter int unsigned MEM_BYTES = 1024
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    data_mem_arbiter_if.slave  a,
    data_mem_arbiter_if.slave  b,
    output logic               mem_we_o,
    output logic [31:0]        mem_addr_o,
    output logic [1:0]         mem_mode_o,
    output logic [31:0]        mem_wdata_o,
    input  logic [31:0]        mem_rdata_i
);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t      state_q, state_d;

    // Latched transaction
    logic        owner_q;       // 0 = port A, 1 = port B
    logic        we_q;
    logic [31:0] addr_q;
    logic [1:0]  mode_q;
    logic [31:0] wdata_q;
    logic [2:0]  len_q;
    logic [1:0]  cnt_q;
    logic        err_q;

    logic        prio_b_q;      // B wins the next tie
    logic        done_a_q, done_b_q;
    logic        err_a_q, err_b_q;
    logic [31:0] rdata_a_q, rdata_b_q;

    logic        gnt_a, gnt_b, gnt_any;
    logic        sel_we;
    logic [31:0] sel_addr, sel_wdata;
    logic [1:0]  sel_mode;
    logic [2:0]  sel_len;
    logic [32:0] sel_end;
    logic        sel_err;
    logic        last_byte, finish;
    logic [7:0]  store_byte;

    // The memory returns the addressed bytes left-justified in the word.
    function automatic logic [31:0] justify_load(input logic [1:0] mode,
                                                 input logic [31:0] raw);
        case (mode)
            2'b00:   return {24'h0, raw[31:24]};
            2'b01:   return {16'h0, raw[31:16]};
            default: return raw;
        endcase
    endfunction

    function automatic logic [2:0] mode_len(input logic [1:0] mode);
        case (mode)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            2'b10:   return 3'd4;
            default: return 3'd1;
        endcase
    endfunction

    // Arbitration and request selection
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (state_q == IDLE) begin
            if (a.req && b.req) begin
                gnt_a = !prio_b_q;
                gnt_b = prio_b_q;
            end else begin
                gnt_a = a.req;
                gnt_b = b.req;
            end
        end
        gnt_any   = gnt_a | gnt_b;

        sel_we    = gnt_b ? b.we    : a.we;
        sel_addr  = gnt_b ? b.addr  : a.addr;
        sel_mode  = gnt_b ? b.mode  : a.mode;
        sel_wdata = gnt_b ? b.wdata : a.wdata;
        sel_len   = mode_len(sel_mode);
        // 33-bit end address so accesses near 0xFFFFFFFF cannot wrap into range
        sel_end   = {1'b0, sel_addr} + {30'h0, sel_len} - 33'd1;
        sel_err   = (sel_mode == 2'b11) || (sel_end >= 33'(MEM_BYTES));
    end

    assign store_byte = wdata_q[{cnt_q, 3'b000} +: 8];

    // Next state and memory-side outputs
    always_comb begin
        last_byte   = ({1'b0, cnt_q} == (len_q - 3'd1));
        finish      = (state_q == ACCESS) && (err_q || !we_q || last_byte);
        state_d     = state_q;
        mem_we_o    = 1'b0;
        mem_addr_o  = 32'h0;
        mem_mode_o  = 2'b10;
        mem_wdata_o = 32'h0;
        case (state_q)
            IDLE: begin
                if (gnt_any) state_d = ACCESS;
            end
            ACCESS: begin
                // A rejected transaction spends its ACCESS cycle with the bus idle
                if (!err_q) begin
                    mem_addr_o = addr_q;
                    mem_mode_o = mode_q;
                    if (we_q) begin
                        mem_we_o    = 1'b1;
                        mem_addr_o  = addr_q + {30'h0, cnt_q};
                        mem_wdata_o = {24'h0, store_byte};
                    end
                end
                if (finish) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= 32'h0;
            mode_q    <= 2'b00;
            wdata_q   <= 32'h0;
            len_q     <= 3'd1;
            cnt_q     <= 2'd0;
            err_q     <= 1'b0;
            prio_b_q  <= 1'b0;
            done_a_q  <= 1'b0;
            done_b_q  <= 1'b0;
            err_a_q   <= 1'b0;
            err_b_q   <= 1'b0;
            rdata_a_q <= 32'h0;
            rdata_b_q <= 32'h0;
        end else begin
            state_q <= state_d;
            if (gnt_any) begin
                owner_q  <= gnt_b;
                we_q     <= sel_we;
                addr_q   <= sel_addr;
                mode_q   <= sel_mode;
                wdata_q  <= sel_wdata;
                len_q    <= sel_len;
                cnt_q    <= 2'd0;
                err_q    <= sel_err;
                // Whoever was just served loses the next tie
                prio_b_q <= gnt_a;
            end else if (state_q == ACCESS) begin
                cnt_q <= cnt_q + 2'd1;
            end

            done_a_q <= finish && !owner_q;
            done_b_q <= finish &&  owner_q;
            err_a_q  <= finish && !owner_q && err_q;
            err_b_q  <= finish &&  owner_q && err_q;

            // Stores leave the owner's last load result untouched
            if (finish && !owner_q) begin
                if (err_q)      rdata_a_q <= 32'h0;
                else if (!we_q) rdata_a_q <= justify_load(mode_q, mem_rdata_i);
            end
            if (finish && owner_q) begin
                if (err_q)      rdata_b_q <= 32'h0;
                else if (!we_q) rdata_b_q <= justify_load(mode_q, mem_rdata_i);
            end
        end
    end

    assign a.gnt   = gnt_a;
    assign b.gnt   = gnt_b;
    assign a.done  = done_a_q;
    assign b.done  = done_b_q;
    assign a.err   = err_a_q;
    assign b.err   = err_b_q;
    assign a.rdata = rdata_a_q;
    assign b.rdata = rdata_b_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_data_mem_arbiter
//   Scoreboard bench for data_mem_arbiter. Drivers raise requests; a monitor
//   predicts arbitration, pushes expected responses and memory writes into
//   queues at grant time, and pops/compares them when the DUT responds.
//   A byte-array memory model sits on the memory port.
// ---------------------------------------------------------------------------
module tb_data_mem_arbiter;
    localparam int          MEM_BYTES = 1024;
    localparam logic [31:0] MEM_LIM   = 32'(MEM_BYTES);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    data_mem_arbiter_if a_if();
    data_mem_arbiter_if b_if();

    logic        mem_we;
    logic [31:0] mem_addr;
    logic [1:0]  mem_mode;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    data_mem_arbiter #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .a           (a_if),
        .b           (b_if),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_mode_o  (mem_mode),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- memory model on the DUT memory port ----------------
    logic [7:0]  mem     [MEM_BYTES];
    logic [7:0]  ref_mem [MEM_BYTES];
    logic        sync_mem = 1'b0;
    logic [31:0] ad1, ad2, ad3;
    logic [7:0]  m0, m1, m2, m3;

    assign ad1 = mem_addr + 32'd1;
    assign ad2 = mem_addr + 32'd2;
    assign ad3 = mem_addr + 32'd3;
    assign m0  = (mem_addr < MEM_LIM) ? mem[mem_addr[9:0]] : 8'h00;
    assign m1  = (ad1 < MEM_LIM) ? mem[ad1[9:0]] : 8'h00;
    assign m2  = (ad2 < MEM_LIM) ? mem[ad2[9:0]] : 8'h00;
    assign m3  = (ad3 < MEM_LIM) ? mem[ad3[9:0]] : 8'h00;

    always_comb begin
        case (mem_mode)
            2'b00:   mem_rdata = {m0, 24'h0};
            2'b01:   mem_rdata = {m1, m0, 16'h0};
            default: mem_rdata = {m3, m2, m1, m0};
        endcase
    end

    always @(posedge clk) begin
        if (sync_mem) begin
            for (int i = 0; i < MEM_BYTES; i++) mem[i] <= ref_mem[i];
        end else if (mem_we && mem_addr < MEM_LIM) begin
            mem[mem_addr[9:0]] <= mem_wdata[7:0];
        end
    end

    // ---------------- reference model / scoreboard state ----------------
    typedef struct { logic err; logic [31:0] rdata; int due; } exp_t;
    typedef struct { logic [31:0] addr; logic [7:0] data; } wr_t;

    exp_t        qa[$];
    exp_t        qb[$];
    wr_t         wq[$];
    int          glog[$];
    logic [31:0] last_rd [2];
    int          busy_until = 0;
    bit          last_a     = 1'b0;

    task automatic model_reset();
        qa.delete();
        qb.delete();
        wq.delete();
        busy_until = 0;
        last_a     = 1'b0;
        last_rd[0] = 32'h0;
        last_rd[1] = 32'h0;
    endtask

    // Predicts the outcome of a transaction accepted in cycle cyc.
    task automatic model_grant(input int p, input logic we, input logic [31:0] addr,
                               input logic [1:0] mode, input logic [31:0] wdata);
        int          len;
        longint      last_ad;
        exp_t        e;
        wr_t         w;
        logic [31:0] ai;
        logic [31:0] val;
        len     = (mode == 2'b00) ? 1 : (mode == 2'b01) ? 2 : 4;
        last_ad = longint'({32'h0, addr}) + len - 1;
        e.err   = (mode == 2'b11) || (last_ad >= MEM_BYTES);
        e.rdata = last_rd[p];
        e.due   = cyc + 2;
        if (e.err) begin
            e.rdata = 32'h0;
        end else if (we) begin
            for (int i = 0; i < len; i++) begin
                ai = addr + 32'(i);
                w.addr = ai;
                w.data = wdata[8*i +: 8];
                wq.push_back(w);
                ref_mem[ai[9:0]] = w.data;
            end
            e.due = cyc + len + 1;
        end else begin
            val = 32'h0;
            for (int i = 0; i < len; i++) begin
                ai  = addr + 32'(i);
                val = val | ({24'h0, ref_mem[ai[9:0]]} << (8 * i));
            end
            e.rdata = val;
        end
        last_rd[p] = e.rdata;
        busy_until = e.due;
        last_a     = (p == 0);
        glog.push_back(p);
        if (p == 0) qa.push_back(e);
        else        qb.push_back(e);
    endtask

    task automatic check_port(input int p, input logic done, input logic err,
                              input logic [31:0] rdata);
        exp_t  e;
        int    n;
        string nm;
        nm = (p == 0) ? "a" : "b";
        n  = (p == 0) ? qa.size() : qb.size();
        if (done) begin
            checks++;
            if (n == 0) begin
                errors++;
                $display("FAIL done_%s: unexpected done at cyc %0d, no transaction pending", nm, cyc);
            end else begin
                if (p == 0) e = qa.pop_front();
                else        e = qb.pop_front();
                if (err !== e.err || rdata !== e.rdata || cyc != e.due) begin
                    errors++;
                    $display("FAIL done_%s: got err=%b rdata=%h at cyc %0d, expected err=%b rdata=%h at cyc %0d",
                             nm, err, rdata, cyc, e.err, e.rdata, e.due);
                end
            end
        end else if (n > 0) begin
            e = (p == 0) ? qa[0] : qb[0];
            if (cyc > e.due) begin
                checks++;
                errors++;
                $display("FAIL done_%s: no done by cyc %0d, expected at cyc %0d", nm, cyc, e.due);
                if (p == 0) void'(qa.pop_front());
                else        void'(qb.pop_front());
            end
        end
    endtask

    // ---------------- monitor ----------------
    logic [1:0] exp_g, got_g;
    wr_t        wexp;

    always @(negedge clk) begin
        if (rst_n) begin
            if (a_if.req || b_if.req || a_if.gnt || b_if.gnt) begin
                exp_g = 2'b00;
                if (cyc >= busy_until) begin
                    if (a_if.req && b_if.req) exp_g = last_a ? 2'b10 : 2'b01;
                    else                      exp_g = {b_if.req, a_if.req};
                end
                got_g = {b_if.gnt, a_if.gnt};
                checks++;
                if (got_g !== exp_g) begin
                    errors++;
                    $display("FAIL grant: cyc %0d got {b,a}=%b expected %b", cyc, got_g, exp_g);
                end
                if (got_g == 2'b01)
                    model_grant(0, a_if.we, a_if.addr, a_if.mode, a_if.wdata);
                else if (got_g == 2'b10)
                    model_grant(1, b_if.we, b_if.addr, b_if.mode, b_if.wdata);
            end

            if (mem_we) begin
                checks++;
                if (wq.size() == 0) begin
                    errors++;
                    $display("FAIL mem_write: unexpected write addr=%h data=%h at cyc %0d", mem_addr, mem_wdata, cyc);
                end else begin
                    wexp = wq.pop_front();
                    if (mem_addr !== wexp.addr || mem_wdata !== {24'h0, wexp.data}) begin
                        errors++;
                        $display("FAIL mem_write: got addr=%h data=%h, expected addr=%h data=%h",
                                 mem_addr, mem_wdata, wexp.addr, {24'h0, wexp.data});
                    end
                end
            end

            check_port(0, a_if.done, a_if.err, a_if.rdata);
            check_port(1, b_if.done, b_if.err, b_if.rdata);
        end
    end

    // ---------------- driver helpers ----------------
    task automatic check32(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Callers are always just after a rising edge.
    task automatic do_req(input int p, input logic we, input logic [31:0] addr,
                          input logic [1:0] mode, input logic [31:0] wdata);
        bit got;
        got = 1'b0;
        if (p == 0) begin
            a_if.we = we; a_if.addr = addr; a_if.mode = mode; a_if.wdata = wdata; a_if.req = 1'b1;
        end else begin
            b_if.we = we; b_if.addr = addr; b_if.mode = mode; b_if.wdata = wdata; b_if.req = 1'b1;
        end
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (((p == 0) ? a_if.gnt : b_if.gnt) === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL gnt_timeout: port %0d not granted within 200 cycles", p);
        end
        @(posedge clk);
        #1;
        if (p == 0) a_if.req = 1'b0;
        else        b_if.req = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((qa.size() != 0 || qb.size() != 0 || wq.size() != 0) && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (k >= 300) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: pending a=%0d b=%0d writes=%0d after 300 cycles", qa.size(), qb.size(), wq.size());
        end
        step(1);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        model_reset();
        step(2);
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic rand_port(input int p);
        logic        we;
        logic [1:0]  md;
        logic [31:0] ad;
        for (int i = 0; i < 40; i++) begin
            we = 1'($urandom_range(0, 1));
            md = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            ad = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, MEM_BYTES + 3));
            do_req(p, we, ad, md, $urandom);
            step($urandom_range(0, 3));
        end
    endtask

    // ---------------- stimulus ----------------
    logic [3:0] ord;
    int         diffs;

    initial begin
        a_if.req = 1'b0; a_if.we = 1'b0; a_if.addr = 32'h0; a_if.mode = 2'b00; a_if.wdata = 32'h0;
        b_if.req = 1'b0; b_if.we = 1'b0; b_if.addr = 32'h0; b_if.mode = 2'b00; b_if.wdata = 32'h0;
        model_reset();
        for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'($urandom);
        sync_mem = 1'b1;
        step(3);
        sync_mem = 1'b0;

        // Reset state
        check32("rst_a_gnt",   {31'h0, a_if.gnt},  32'h0);
        check32("rst_a_done",  {31'h0, a_if.done}, 32'h0);
        check32("rst_b_err",   {31'h0, b_if.err},  32'h0);
        check32("rst_a_rdata", a_if.rdata,         32'h0);
        check32("rst_b_rdata", b_if.rdata,         32'h0);
        check32("rst_mem_we",  {31'h0, mem_we},    32'h0);
        check32("rst_mem_addr", mem_addr,          32'h0);
        check32("rst_mem_mode", {30'h0, mem_mode}, 32'h2);
        check32("rst_mem_wdata", mem_wdata,        32'h0);
        rst_n = 1'b1;
        step(2);

        // Word store then load on port A
        do_req(0, 1'b1, 32'd8, 2'b10, 32'h88913416);
        wait_idle();
        check32("store_bytes_8_11", {mem[11], mem[10], mem[9], mem[8]}, 32'h88913416);
        do_req(0, 1'b0, 32'd8, 2'b10, 32'h0);
        wait_idle();
        check32("word_load_a", a_if.rdata, 32'h88913416);

        // Half and byte loads on port B
        do_req(1, 1'b1, 32'd4, 2'b10, 32'h88913416);
        wait_idle();
        do_req(1, 1'b0, 32'd6, 2'b01, 32'h0);
        wait_idle();
        check32("half_load_6", b_if.rdata, 32'h00008891);
        do_req(1, 1'b0, 32'd5, 2'b00, 32'h0);
        wait_idle();
        check32("byte_load_5", b_if.rdata, 32'h00000034);

        // Contention straight after reset: A, B, A, B
        pulse_reset();
        glog.delete();
        fork
            begin
                do_req(0, 1'b0, 32'd100, 2'b10, 32'h0);
                do_req(0, 1'b0, 32'd200, 2'b01, 32'h0);
            end
            begin
                do_req(1, 1'b0, 32'd300, 2'b00, 32'h0);
                do_req(1, 1'b0, 32'd400, 2'b10, 32'h0);
            end
        join
        wait_idle();
        check32("contention_count", glog.size(), 32'd4);
        ord = 4'hF;
        if (glog.size() >= 4) ord = {glog[0][0], glog[1][0], glog[2][0], glog[3][0]};
        check32("contention_order", {28'h0, ord}, 32'h5);

        // Request from B arriving during a store by A must wait
        fork
            do_req(0, 1'b1, 32'd40, 2'b10, 32'hCAFEF00D);
            begin
                step(2);
                do_req(1, 1'b0, 32'd40, 2'b10, 32'h0);
            end
        join
        wait_idle();
        check32("load_after_store", b_if.rdata, 32'hCAFEF00D);

        // Error cases
        do_req(0, 1'b0, 32'd0, 2'b11, 32'h0);
        wait_idle();
        check32("err_mode11_rdata", a_if.rdata, 32'h0);
        do_req(1, 1'b1, 32'd1022, 2'b10, 32'h12345678);
        wait_idle();
        check32("err_store_1022_rdata", b_if.rdata, 32'h0);
        check32("err_store_1022_mem", {mem[1023], mem[1022]}, {ref_mem[1023], ref_mem[1022]});
        do_req(0, 1'b0, 32'd8, 2'b10, 32'h0);
        wait_idle();
        do_req(0, 1'b0, 32'hFFFF_FFFE, 2'b10, 32'h0);
        wait_idle();
        check32("err_wrap_rdata", a_if.rdata, 32'h0);

        // Reset in the middle of a word store
        ref_mem[16] = 8'h11; ref_mem[17] = 8'h22; ref_mem[18] = 8'h5A; ref_mem[19] = 8'hA5;
        sync_mem = 1'b1;
        step(1);
        sync_mem = 1'b0;
        do_req(0, 1'b1, 32'd16, 2'b10, 32'hAABBCCDD);
        @(posedge clk);
        @(posedge clk);
        #2;
        check32("midstore_we_before_rst", {31'h0, mem_we}, 32'h1);
        rst_n = 1'b0;
        #1;
        check32("midstore_we_async_drop", {31'h0, mem_we}, 32'h0);
        model_reset();
        ref_mem[18] = 8'h5A;
        ref_mem[19] = 8'hA5;
        step(2);
        check32("midstore_no_done", {31'h0, a_if.done}, 32'h0);
        rst_n = 1'b1;
        step(1);
        check32("midstore_bytes", {mem[19], mem[18], mem[17], mem[16]}, 32'hA55ACCDD);
        do_req(0, 1'b0, 32'd16, 2'b10, 32'h0);
        wait_idle();
        check32("after_reset_load", a_if.rdata, 32'hA55ACCDD);

        // Randomized traffic from both ports
        fork
            rand_port(0);
            rand_port(1);
        join
        wait_idle();

        diffs = 0;
        for (int i = 0; i < MEM_BYTES; i++) if (mem[i] !== ref_mem[i]) diffs++;
        check32("final_mem_diffs", diffs, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
